conv_encoder_322: RTL and testbench

//  Rate-2/3, 8-state (3,2,2) convolutional encoder: transmit-side counterpart of the e322 Viterbi decoder.

---
 rtl/conv_encoder_322.sv | 122 ++++++++++++
 tb/tb_conv_encoder_322.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_322.sv
// Rate-2/3, 8-state (3,2,2) convolutional encoder with two zero tail pairs per frame.
// Single registered output stage; the trellis state only advances when a symbol is loaded.
module conv_encoder_322 #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_sym,
  output logic       out_tail,
  output logic       out_last,
  output logic [2:0] enc_state
);

  typedef enum logic [1:0] {DATA, TAIL1, TAIL2} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_sym_q, out_sym_d;
  logic             out_tail_q, out_tail_d;
  logic             out_last_q, out_last_d;

  logic load;
  logic encode;
  logic u1, u2;
  logic a, b, c;

  assign {a, b, c} = state_q;

  always_comb begin
    load        = !out_valid_q || out_ready;
    in_ready    = load && (fsm_q == DATA);
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_tail_d  = out_tail_q;
    out_last_d  = out_last_q;
    encode      = 1'b0;
    u1          = 1'b0;
    u2          = 1'b0;

    // Everything below only moves when the output register can be (re)loaded.
    if (load) begin
      out_valid_d = 1'b0;
      out_tail_d  = 1'b0;
      out_last_d  = 1'b0;
      unique case (fsm_q)
        DATA: begin
          if (in_valid) begin
            encode = 1'b1;
            u1     = in_data[0];
            u2     = in_data[1];
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
              cnt_d = '0;
              fsm_d = TAIL1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        TAIL1: begin
          encode     = 1'b1;
          out_tail_d = 1'b1;
          fsm_d      = TAIL2;
        end
        TAIL2: begin
          encode     = 1'b1;
          out_tail_d = 1'b1;
          out_last_d = 1'b1;
          fsm_d      = DATA;
        end
        default: fsm_d = DATA;
      endcase

      if (encode) begin
        out_valid_d = 1'b1;
        out_sym_d   = {u1 ^ u2 ^ a ^ c, u2 ^ a ^ c, u1 ^ b};
        state_d     = {u1, u2, b};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= DATA;
      state_q     <= 3'b000;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 3'b000;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_tail_q  <= out_tail_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_tail  = out_tail_q;
  assign out_last  = out_last_q;
  assign enc_state = state_q;

  // Two zero tail pairs must always drive the trellis home to 000.
  a_tail_terminates: assert property (@(posedge clk) disable iff (!reset_n)
    (fsm_q == TAIL2 && load) |=> (state_q == 3'b000));

endmodule

// File: tb/tb_conv_encoder_322.sv
// Directed bench for conv_encoder_322: one 2-pair-frame instance and one 16-pair-frame instance
// share the stimulus; each scenario checks only the instance it targets.
module tb_conv_encoder_322;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [1:0] in_data;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_tail_a, out_last_a;
  logic [2:0] out_sym_a, enc_state_a;
  logic       in_ready_b, out_valid_b, out_tail_b, out_last_b;
  logic [2:0] out_sym_b, enc_state_b;

  int checks = 0;
  int errors = 0;

  conv_encoder_322 #(.FRAME_LEN(2), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sym(out_sym_a), .out_tail(out_tail_a), .out_last(out_last_a),
    .enc_state(enc_state_a)
  );

  conv_encoder_322 #(.FRAME_LEN(16), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sym(out_sym_b), .out_tail(out_tail_b), .out_last(out_last_b),
    .enc_state(enc_state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference trellis: returns {next_state, sym}.
  function automatic logic [5:0] ref_enc(input logic [2:0] s, input logic v1, input logic v2);
    logic sa, sb, sc;
    {sa, sb, sc} = s;
    return {v1, v2, sb, v1 ^ v2 ^ sa ^ sc, v2 ^ sa ^ sc, v1 ^ sb};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; in_data = 2'b00; out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = 2'b00; out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid_a, out_sym_a, out_tail_a, out_last_a, enc_state_a} !== 9'b0) begin
      errors++; $display("FAIL reset_a: got %b expected %b", {out_valid_a, out_sym_a, out_tail_a, out_last_a, enc_state_a}, 9'b0);
    end
    checks++;
    if ({out_valid_b, out_sym_b, out_tail_b, out_last_b, enc_state_b} !== 9'b0) begin
      errors++; $display("FAIL reset_b: got %b expected %b", {out_valid_b, out_sym_b, out_tail_b, out_last_b, enc_state_b}, 9'b0);
    end
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  // Two-pair frame (1,0),(0,1), tail inserted while in_valid is low, then idle drop.
  task automatic test_frame();
    do_reset();
    in_valid = 1'b1; in_data = 2'b01;
    @(negedge clk);
    checks++;
    if ({out_valid_a, out_sym_a, out_tail_a, enc_state_a} !== {1'b1, 3'b101, 1'b0, 3'b100}) begin
      errors++; $display("FAIL frame_sym0: got %b expected %b", {out_valid_a, out_sym_a, out_tail_a, enc_state_a}, {1'b1, 3'b101, 1'b0, 3'b100});
    end
    in_data = 2'b10;
    @(negedge clk);
    checks++;
    if ({out_sym_a, out_tail_a, enc_state_a, in_ready_a} !== {3'b000, 1'b0, 3'b010, 1'b0}) begin
      errors++; $display("FAIL frame_sym1: got %b expected %b", {out_sym_a, out_tail_a, enc_state_a, in_ready_a}, {3'b000, 1'b0, 3'b010, 1'b0});
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid_a, out_sym_a, out_tail_a, out_last_a, in_ready_a} !== {1'b1, 3'b001, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL frame_tail1: got %b expected %b", {out_valid_a, out_sym_a, out_tail_a, out_last_a, in_ready_a}, {1'b1, 3'b001, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({out_valid_a, out_sym_a, out_tail_a, out_last_a, enc_state_a, in_ready_a} !== {1'b1, 3'b110, 1'b1, 1'b1, 3'b000, 1'b1}) begin
      errors++; $display("FAIL frame_tail2: got %b expected %b", {out_valid_a, out_sym_a, out_tail_a, out_last_a, enc_state_a, in_ready_a}, {1'b1, 3'b110, 1'b1, 1'b1, 3'b000, 1'b1});
    end
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++; $display("FAIL frame_idle: got out_valid %b expected 0", out_valid_a);
    end
    $display("test_frame done");
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_data = 2'b01;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++; $display("FAIL bp_ready0: got %b expected 1", in_ready_a);
    end
    @(negedge clk);
    out_ready = 1'b0; in_data = 2'b10;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid_a, out_sym_a, enc_state_a, in_ready_a} !== {1'b1, 3'b101, 3'b100, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got %b expected %b", k, {out_valid_a, out_sym_a, enc_state_a, in_ready_a}, {1'b1, 3'b101, 3'b100, 1'b0});
      end
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++; $display("FAIL bp_release: got in_ready %b expected 1", in_ready_a);
    end
    @(negedge clk);
    checks++;
    if ({out_sym_a, out_tail_a, enc_state_a} !== {3'b000, 1'b0, 3'b010}) begin
      errors++; $display("FAIL bp_resume: got %b expected %b", {out_sym_a, out_tail_a, enc_state_a}, {3'b000, 1'b0, 3'b010});
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_sym_a, out_last_a} !== {3'b110, 1'b1}) begin
      errors++; $display("FAIL bp_last: got %b expected %b", {out_sym_a, out_last_a}, {3'b110, 1'b1});
    end
    $display("test_backpressure done");
  endtask

  task automatic test_zero_frame();
    do_reset();
    in_data = 2'b00;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      #1;
      checks++;
      if (in_ready_b !== (i < 16)) begin
        errors++; $display("FAIL zero_ready%0d: got %b expected %b", i, in_ready_b, (i < 16));
      end
      @(negedge clk);
      checks++;
      if ({out_valid_b, out_sym_b, out_tail_b, out_last_b} !== {1'b1, 3'b000, (i >= 16), (i == 17)}) begin
        errors++; $display("FAIL zero_sym%0d: got %b expected %b", i, {out_valid_b, out_sym_b, out_tail_b, out_last_b}, {1'b1, 3'b000, (i >= 16), (i == 17)});
      end
    end
    in_valid = 1'b0;
    $display("test_zero_frame done");
  endtask

  // Two frames with in_valid held high; data offered during tails must be ignored.
  task automatic test_back_to_back();
    logic [1:0] dat [8] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11};
    logic [2:0] es  [8] = '{3'b101, 3'b000, 3'b001, 3'b110, 3'b011, 3'b111, 3'b110, 3'b000};
    logic [2:0] est [8] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000};
    logic       et  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       el  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       rdy [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = dat[i];
      #1;
      checks++;
      if (in_ready_a !== rdy[i]) begin
        errors++; $display("FAIL b2b_ready%0d: got %b expected %b", i, in_ready_a, rdy[i]);
      end
      @(negedge clk);
      checks++;
      if ({out_valid_a, out_sym_a, out_tail_a, out_last_a, enc_state_a} !== {1'b1, es[i], et[i], el[i], est[i]}) begin
        errors++; $display("FAIL b2b_sym%0d: got %b expected %b", i, {out_valid_a, out_sym_a, out_tail_a, out_last_a, enc_state_a}, {1'b1, es[i], et[i], el[i], est[i]});
      end
    end
    in_valid = 1'b0;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    in_valid = 1'b1; in_data = 2'b01;
    for (int i = 0; i < 5; i++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_b, out_sym_b, out_tail_b, out_last_b, enc_state_b} !== 9'b0) begin
      errors++; $display("FAIL midrst_clear: got %b expected %b", {out_valid_b, out_sym_b, out_tail_b, out_last_b, enc_state_b}, 9'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = (i < 16);
      in_data  = (i == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
      checks++;
      if ({out_valid_b, out_sym_b, out_tail_b} !== {1'b1, (i == 0) ? 3'b101 : ((i == 1) ? 3'b110 : 3'b000), (i == 16)}) begin
        errors++; $display("FAIL midrst_sym%0d: got %b expected %b", i, {out_valid_b, out_sym_b, out_tail_b}, {1'b1, (i == 0) ? 3'b101 : ((i == 1) ? 3'b110 : 3'b000), (i == 16)});
      end
    end
    in_valid = 1'b0;
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_random_stream();
    localparam int NF = 12;
    localparam int NP = 2 * NF;
    logic [1:0] pairs [NP];
    logic [4:0] exp_q [$];
    logic [2:0] s;
    logic [5:0] r;
    int idx;
    int cyc;
    s = 3'b000;
    for (int f = 0; f < NF; f++) begin
      for (int p = 0; p < 2; p++) begin
        pairs[2*f+p] = 2'($urandom_range(0, 3));
        r = ref_enc(s, pairs[2*f+p][0], pairs[2*f+p][1]);
        s = r[5:3];
        exp_q.push_back({2'b00, r[2:0]});
      end
      r = ref_enc(s, 1'b0, 1'b0); s = r[5:3]; exp_q.push_back({2'b01, r[2:0]});
      r = ref_enc(s, 1'b0, 1'b0); s = r[5:3]; exp_q.push_back({2'b11, r[2:0]});
    end
    do_reset();
    idx = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (idx < NP) && ($urandom_range(0, 3) != 0);
      in_data   = (idx < NP) ? pairs[idx] : 2'b00;
      #1;
      if (out_valid_a && out_ready) begin
        checks++;
        if ({out_last_a, out_tail_a, out_sym_a} !== exp_q[0]) begin
          errors++; $display("FAIL rand_sym%0d: got %b expected %b", cyc, {out_last_a, out_tail_a, out_sym_a}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready_a) idx++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_timeout: %0d symbols still expected after %0d cycles", exp_q.size(), cyc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    $display("test_random_stream done: %0d cycles", cyc);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_zero_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
